// File: rtl/alarm_pkg.sv
// Shared alarm clock UI types and constants.
// Contents: btn_state_t (button event decoder FSM states), CLK_FREQ_HZ (system clock rate).
package alarm_pkg;

    localparam int unsigned CLK_FREQ_HZ = 38_000_000;

    typedef enum logic [1:0] {
        WAIT_REL,
        IDLE,
        PRESSED,
        LONG_HELD
    } btn_state_t;

endpackage : alarm_pkg

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into short/long/repeat event pulses and a held level.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-low reset
//   in_btn       in   debounced button level, 1 = pressed
//   short_press  out  1-cycle pulse on release of a press shorter than LONG_CYCLES
//   long_press   out  1-cycle pulse when the hold reaches LONG_CYCLES samples
//   repeat_tick  out  1-cycle pulse every REPEAT_CYCLES while held past long_press
//   held         out  level, 1 while a valid press is in progress
module button_event_decoder
    import alarm_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = 38_000_000,
    parameter int unsigned REPEAT_CYCLES = 7_600_000,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_btn,
    output logic short_press,
    output logic long_press,
    output logic repeat_tick,
    output logic held
);

    localparam int unsigned CNT_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    btn_state_t       r_state;
    btn_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_short_nxt;
    logic             w_long_nxt;
    logic             w_repeat_nxt;
    logic             w_held_nxt;

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= WAIT_REL;
            r_cnt       <= '0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
            repeat_tick <= 1'b0;
            held        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            short_press <= w_short_nxt;
            long_press  <= w_long_nxt;
            repeat_tick <= w_repeat_nxt;
            held        <= w_held_nxt;
        end
    end

    // Next-state, counter and event decode
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_short_nxt  = 1'b0;
        w_long_nxt   = 1'b0;
        w_repeat_nxt = 1'b0;

        unique case (r_state)
            // A button still down after reset must be released before it can generate events
            WAIT_REL: begin
                w_cnt_nxt = '0;
                if (!in_btn) begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                w_cnt_nxt = '0;
                if (in_btn) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!in_btn) begin
                    w_state_nxt = IDLE;
                    w_short_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LONG_LAST) begin
                    w_state_nxt = LONG_HELD;
                    w_long_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            LONG_HELD: begin
                if (!in_btn) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == REPEAT_LAST) begin
                    w_repeat_nxt = REPEAT_EN;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = WAIT_REL;
                w_cnt_nxt   = '0;
            end
        endcase

        w_held_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == LONG_HELD);
    end

endmodule : button_event_decoder

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_CYCLES=8, REPEAT_CYCLES=4.
// Two instances share stimulus: u_dut (REPEAT_EN=1) and u_dut_nr (REPEAT_EN=0).
// Outputs are compared as {short_press, long_press, repeat_tick, held}.
module tb_button_event_decoder;

    localparam int unsigned L = 8;
    localparam int unsigned R = 4;

    logic clk;
    logic reset;
    logic in_btn;
    logic sp, lp, rt, hd;
    logic sp_nr, lp_nr, rt_nr, hd_nr;

    int n_checks;
    int n_fail;

    button_event_decoder #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b1)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .in_btn      (in_btn),
        .short_press (sp),
        .long_press  (lp),
        .repeat_tick (rt),
        .held        (hd)
    );

    button_event_decoder #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b0)) u_dut_nr (
        .clk         (clk),
        .reset       (reset),
        .in_btn      (in_btn),
        .short_press (sp_nr),
        .long_press  (lp_nr),
        .repeat_tick (rt_nr),
        .held        (hd_nr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {sp,lp,rt,held}=%b expected %b", tag, got, exp);
        end
    endtask

    // Apply one input sample and check both instances one step after the edge
    task automatic step(input logic rst_v, input logic btn, input string tag,
                        input logic [3:0] exp, input logic [3:0] exp_nr);
        reset  = rst_v;
        in_btn = btn;
        @(posedge clk);
        #1;
        check({tag, " en1"}, {sp, lp, rt, hd}, exp);
        check({tag, " en0"}, {sp_nr, lp_nr, rt_nr, hd_nr}, exp_nr);
    endtask

    // Press for n high samples from IDLE, then release; expectations from the event timing rules
    task automatic press(input int n, input string tag);
        logic e_lp, e_rt;
        for (int i = 1; i <= n; i++) begin
            e_lp = (i == int'(L));
            e_rt = (i > int'(L)) && (((i - int'(L)) % int'(R)) == 0);
            step(1'b1, 1'b1, $sformatf("%s s%0d", tag, i),
                 {1'b0, e_lp, e_rt, 1'b1}, {1'b0, e_lp, 1'b0, 1'b1});
        end
        step(1'b1, 1'b0, $sformatf("%s rel", tag),
             {(n < int'(L)), 3'b000}, {(n < int'(L)), 3'b000});
        step(1'b1, 1'b0, $sformatf("%s idle", tag), 4'b0000, 4'b0000);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        in_btn   = 1'b0;

        // Reset state, then leave WAIT_REL with the button up
        step(1'b0, 1'b0, "rst0", 4'b0000, 4'b0000);
        step(1'b0, 1'b0, "rst1", 4'b0000, 4'b0000);
        step(1'b1, 1'b0, "rst_exit", 4'b0000, 4'b0000);

        press(3,  "short3");
        press(8,  "long8");
        press(20, "rep20");
        press(1,  "glitch");
        press(7,  "rel_at_long");
        press(15, "rel_at_rep");

        // Button held through reset produces nothing until released
        step(1'b0, 1'b1, "hrst0", 4'b0000, 4'b0000);
        step(1'b0, 1'b1, "hrst1", 4'b0000, 4'b0000);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b1, $sformatf("hold_after_rst s%0d", i), 4'b0000, 4'b0000);
        end
        step(1'b1, 1'b0, "hold_after_rst rel", 4'b0000, 4'b0000);
        press(2, "post_rst");

        // Reset at press sample 6 drops the press silently
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b1, $sformatf("midrst s%0d", i), 4'b0001, 4'b0001);
        end
        step(1'b0, 1'b1, "midrst s6", 4'b0000, 4'b0000);
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b1, $sformatf("midrst hold%0d", i), 4'b0000, 4'b0000);
        end
        step(1'b1, 1'b0, "midrst rel", 4'b0000, 4'b0000);
        press(3, "after_midrst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_button_event_decoder
